// File: rtl/ldtu_ecc_pkg.sv
// ldtu_ecc_pkg: SECDED codeword geometry, encoder/decoder functions and shared LDTU idle words
package ldtu_ecc_pkg;
  localparam int DATA_W = 32;
  localparam int ECC_W = 7;
  localparam int CW_W = DATA_W + ECC_W;
  localparam int SYN_W = ECC_W - 1;
  localparam logic [31:0] IDLE_EA = 32'hEAAAAAAA;
  localparam logic [31:0] IDLE_5A = 32'h5A5A5A5A;
  function automatic logic [SYN_W-1:0] secded_syn(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int i = 1; i < CW_W; i++) if (cw[i]) s ^= SYN_W'(i);
    return s;
  endfunction
  // bit 0 is overall parity, Hamming check bits sit at power-of-two positions
  function automatic logic [CW_W-1:0] secded_enc(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    logic [SYN_W-1:0] s;
    int k;
    c = '0;
    k = 0;
    for (int i = 1; i < CW_W; i++) if ((i & (i - 1)) != 0) begin
      c[i] = d[k];
      k++;
    end
    s = secded_syn(c);
    for (int j = 0; j < SYN_W; j++) c[1 << j] = s[j];
    c[0] = ^c[CW_W-1:1];
    return c;
  endfunction
  function automatic logic [DATA_W+1:0] secded_dec(input logic [CW_W-1:0] cw);
    logic [CW_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [SYN_W-1:0] s;
    logic p;
    int k;
    c = cw;
    d = '0;
    s = secded_syn(cw);
    p = ^cw;
    if (p && int'(s) < CW_W) c[s] = ~c[s];
    k = 0;
    for (int i = 1; i < CW_W; i++) if ((i & (i - 1)) != 0) begin
      d[k] = c[i];
      k++;
    end
    return {d, p, (|s) & ~p};
  endfunction
endpackage

// File: rtl/ldtu_secded_dec.sv
// ldtu_secded_dec: combinational SECDED decoder in front of the read data register
module ldtu_secded_dec
  import ldtu_ecc_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output logic              sec,
  output logic              ded
);
  assign {data, sec, ded} = secded_dec(cw);
endmodule

// File: rtl/ldtu_ofifo_secded.sv
// ldtu_ofifo_secded: SECDED-protected output FIFO with idle word, status, overflow and SEU counters
module ldtu_ofifo_secded
  import ldtu_ecc_pkg::*;
#(
  parameter int DATA_W = ldtu_ecc_pkg::DATA_W,
  parameter int ECC_W = ldtu_ecc_pkg::ECC_W,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = 12,
  parameter int CNT_W = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD = IDLE_EA
) (
  input  logic                     CLK,
  input  logic                     rst_b,
  input  logic                     write_signal,
  input  logic                     read_signal,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [1:0]               err_inj,
  input  logic                     cnt_clr,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full_signal,
  output logic                     empty_signal,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     sec_err,
  output logic                     ded_err,
  output logic                     overflow,
  output logic [CNT_W-1:0]         sec_cnt,
  output logic [CNT_W-1:0]         ded_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [CW_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CW_W-1:0] wr_cw;
  logic [DATA_W-1:0] dec_data;
  logic dec_sec, dec_ded, wr_en, rd_en, rd_sec, rd_ded;
  assign occupancy = wr_ptr - rd_ptr;
  assign full_signal = occupancy == (AW+1)'(DEPTH);
  assign empty_signal = occupancy == '0;
  assign almost_full = occupancy >= (AW+1)'(AF_THRESH);
  assign wr_en = write_signal & ~full_signal;
  assign rd_en = read_signal & ~empty_signal;
  assign rd_sec = rd_en & dec_sec;
  assign rd_ded = rd_en & dec_ded;
  assign wr_cw = secded_enc(data_in) ^ {{(CW_W-2){1'b0}}, err_inj[1], |err_inj};
  ldtu_secded_dec u_dec (
    .cw  (mem[rd_ptr[AW-1:0]]),
    .data(dec_data),
    .sec (dec_sec),
    .ded (dec_ded)
  );
  always_ff @(posedge CLK) if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_cw;
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_out <= IDLE_WORD;
      sec_err <= 1'b0;
      ded_err <= 1'b0;
      overflow <= 1'b0;
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (read_signal) data_out <= empty_signal ? IDLE_WORD : dec_data;
      sec_err <= rd_sec;
      ded_err <= rd_ded;
      overflow <= ~cnt_clr & (overflow | (write_signal & full_signal));
      sec_cnt <= cnt_clr ? '0 : sec_cnt + CNT_W'(rd_sec & ~&sec_cnt);
      ded_cnt <= cnt_clr ? '0 : ded_cnt + CNT_W'(rd_ded & ~&ded_cnt);
    end
  end
endmodule

// File: tb/tb_ldtu_ofifo_secded.sv
// tb_ldtu_ofifo_secded: scoreboard bench against a reference FIFO model with injected SEUs
module tb_ldtu_ofifo_secded;
  localparam logic [31:0] IDLE = 32'hEAAAAAAA;
  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
  } exp_t;
  logic CLK = 1'b0, rst_b = 1'b0;
  logic write_signal = 1'b0, read_signal = 1'b0, cnt_clr = 1'b0;
  logic [31:0] data_in = '0;
  logic [1:0] err_inj = '0;
  logic [31:0] data_out;
  logic full_signal, empty_signal, almost_full, sec_err, ded_err, overflow;
  logic [4:0] occupancy;
  logic [7:0] sec_cnt, ded_cnt;
  int checks = 0, passes = 0;
  exp_t sb[$];
  logic [31:0] m_d[$];
  logic [1:0] m_i[$];
  logic [31:0] m_out = IDLE;
  logic m_ovf = 1'b0;
  int m_sc = 0, m_dc = 0;

  ldtu_ofifo_secded dut (
    .CLK(CLK), .rst_b(rst_b), .write_signal(write_signal), .read_signal(read_signal),
    .data_in(data_in), .err_inj(err_inj), .cnt_clr(cnt_clr), .data_out(data_out),
    .full_signal(full_signal), .empty_signal(empty_signal), .almost_full(almost_full),
    .occupancy(occupancy), .sec_err(sec_err), .ded_err(ded_err), .overflow(overflow),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  task automatic status();
    chk("occupancy", occupancy, m_d.size());
    chk("full", full_signal, m_d.size() == 16);
    chk("empty", empty_signal, m_d.size() == 0);
    chk("almost_full", almost_full, m_d.size() >= 12);
    chk("overflow", overflow, m_ovf);
    chk("sec_cnt", sec_cnt, m_sc);
    chk("ded_cnt", ded_cnt, m_dc);
  endtask

  task automatic cycle(input logic w, input logic r, input logic [31:0] d,
                       input logic [1:0] inj, input logic clr);
    exp_t x, y;
    logic [1:0] pi;
    logic was_full;
    was_full = m_d.size() == 16;
    write_signal = w;
    read_signal = r;
    data_in = d;
    err_inj = inj;
    cnt_clr = clr;
    x.s = 1'b0;
    x.e = 1'b0;
    if (r) begin
      if (m_d.size() == 0) m_out = IDLE;
      else begin
        m_out = m_d.pop_front();
        pi = m_i.pop_front();
        x.s = pi == 2'b01;
        x.e = pi[1];
      end
    end
    x.d = m_out;
    if (w && was_full) m_ovf = 1'b1;
    else if (w) begin
      m_d.push_back(d);
      m_i.push_back(inj);
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_sc = 0;
      m_dc = 0;
    end else begin
      if (x.s && m_sc < 255) m_sc++;
      if (x.e && m_dc < 255) m_dc++;
    end
    sb.push_back(x);
    @(posedge CLK);
    #1;
    y = sb.pop_front();
    chk("data_out", data_out, y.d);
    chk("sec_err", sec_err, y.s);
    chk("ded_err", ded_err, y.e);
    status();
    write_signal = 1'b0;
    read_signal = 1'b0;
    err_inj = '0;
    cnt_clr = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst data_out", data_out, IDLE);
    chk("rst sec_err", sec_err, 1'b0);
    chk("rst ded_err", ded_err, 1'b0);
    status();
    rst_b = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) cycle(0, 1, '0, 0, 0);
    for (int i = 0; i < 17; i++) cycle(1, 0, i == 16 ? 32'h99 : i, 0, 0);
    chk("overflow after 17th write", overflow, 1'b1);
    for (int i = 0; i < 17; i++) cycle(0, 1, '0, 0, 0);
    chk("idle after drain", data_out, IDLE);
    cycle(0, 0, '0, 0, 1);
    cycle(1, 0, 32'hDEADBEEF, 2'b01, 0);
    cycle(0, 1, '0, 0, 0);
    chk("sec corrected", data_out, 32'hDEADBEEF);
    chk("sec_cnt one", sec_cnt, 8'd1);
    cycle(0, 0, '0, 0, 0);
    cycle(1, 0, 32'h12345678, 2'b10, 0);
    cycle(0, 1, '0, 0, 0);
    chk("ded_cnt one", ded_cnt, 8'd1);
    cycle(1, 1, 32'hA5A5_0001, 0, 0);
    chk("wr+rd empty occ", occupancy, 5'd1);
    for (int i = 0; i < 15; i++) cycle(1, 0, 32'h100 + i, 0, 0);
    cycle(1, 1, 32'hBAD, 0, 0);
    chk("wr+rd full occ", occupancy, 5'd15);
    cycle(0, 0, '0, 0, 1);
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 32'h200 + i, 0, 0);
    #2 rst_b = 1'b0;
    #1;
    m_d.delete();
    m_i.delete();
    m_out = IDLE;
    m_ovf = 1'b0;
    m_sc = 0;
    m_dc = 0;
    chk("async rst data_out", data_out, IDLE);
    chk("async rst empty", empty_signal, 1'b1);
    status();
    #2 rst_b = 1'b1;
    @(posedge CLK);
    #1;
    cycle(1, 0, 32'hDEADBEEF, 2'b01, 0);
    for (int i = 0; i < 260; i++) cycle(1, 1, 32'hDEADBEEF, 2'b01, 0);
    chk("sec_cnt saturated", sec_cnt, 8'hFF);
    cycle(0, 0, '0, 0, 1);
    chk("sec_cnt cleared", sec_cnt, 8'h00);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
